// File: rtl/amm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM slave among NUM_M single-beat masters; grant is registered one edge after request.
// Latency: request seen at edge N is driven on m_* from N+1; the granted master sees the slave's waitrequest, all others are held at 1.
module amm_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int BW   = DW / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_M*AW-1:0]   s_address,
  input  logic [NUM_M*BW-1:0]   s_byteenable,
  input  logic [NUM_M*DW-1:0]   s_writedata,
  input  logic [NUM_M-1:0]      s_read,
  input  logic [NUM_M-1:0]      s_write,
  output logic [NUM_M-1:0]      s_waitrequest,
  output logic [DW-1:0]         s_readdata,
  output logic [AW-1:0]         m_address,
  output logic [BW-1:0]         m_byteenable,
  output logic [DW-1:0]         m_writedata,
  output logic                  m_read,
  output logic                  m_write,
  input  logic                  m_waitrequest,
  input  logic [DW-1:0]         m_readdata,
  output logic [NUM_M-1:0]      grant
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q;
  logic [NUM_M-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    ptr_q;

  logic [NUM_M-1:0] req;
  logic [IW-1:0]    gidx_d;
  logic [IW-1:0]    ptr_d;
  logic [IW-1:0]    hi_idx;
  logic [IW-1:0]    lo_idx;
  logic             hi_vld;
  logic             lo_vld;
  logic             busy;
  logic             g_rd;
  logic             g_wr;
  logic             done;
  logic             abandon;

  assign req = s_read | s_write;

  // lo_* is the lowest requester overall, hi_* the lowest at or above the pointer; hi wins, lo covers the wrap.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NUM_M - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_vld = 1'b1;
        lo_idx = IW'(j);
        if (IW'(j) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = IW'(j);
        end
      end
    end
  end

  assign gidx_d = hi_vld ? hi_idx : lo_idx;
  assign ptr_d  = (gidx_q == IW'(NUM_M - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    g_rd         = 1'b0;
    g_wr         = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      if (gidx_q == IW'(j)) begin
        m_address    = s_address[j*AW +: AW];
        m_byteenable = s_byteenable[j*BW +: BW];
        m_writedata  = s_writedata[j*DW +: DW];
        g_rd         = s_read[j];
        g_wr         = s_write[j];
      end
    end
  end

  assign busy          = (state_q == BUSY);
  assign m_read        = busy & g_rd;
  assign m_write       = busy & g_wr & ~g_rd;
  assign s_readdata    = m_readdata;
  assign s_waitrequest = busy ? (~grant_q | {NUM_M{m_waitrequest}}) : '1;
  assign grant         = grant_q;

  assign done    = busy & (m_read | m_write) & ~m_waitrequest;
  assign abandon = busy & ~(g_rd | g_wr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lo_vld) begin
            state_q <= BUSY;
            gidx_q  <= gidx_d;
            grant_q <= NUM_M'(1) << gidx_d;
          end
        end
        BUSY: begin
          if (done || abandon) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amm_rr_arbiter.sv
// Bench for amm_rr_arbiter with four masters: directed scenarios, then a random soak against a transaction-level model.
module tb_amm_rr_arbiter;

  localparam int NM     = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int BW     = 4;
  localparam int SOAK_N = 10000;

  logic             clk;
  logic             reset_n;
  logic [NM*AW-1:0] s_address;
  logic [NM*BW-1:0] s_byteenable;
  logic [NM*DW-1:0] s_writedata;
  logic [NM-1:0]    s_read;
  logic [NM-1:0]    s_write;
  logic [NM-1:0]    s_waitrequest;
  logic [DW-1:0]    s_readdata;
  logic [AW-1:0]    m_address;
  logic [BW-1:0]    m_byteenable;
  logic [DW-1:0]    m_writedata;
  logic             m_read;
  logic             m_write;
  logic             m_waitrequest;
  logic [DW-1:0]    m_readdata;
  logic [NM-1:0]    grant;

  amm_rr_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_address     (s_address),
    .s_byteenable  (s_byteenable),
    .s_writedata   (s_writedata),
    .s_read        (s_read),
    .s_write       (s_write),
    .s_waitrequest (s_waitrequest),
    .s_readdata    (s_readdata),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_writedata   (m_writedata),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .grant         (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int          m;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sbq[$];

  // Transaction-level model: decides the winner of each idle cycle and predicts the slave-side transfer.
  int            mon_ptr;
  bit            mon_idle;
  int            mon_w;
  int            mon_wait [NM];
  logic [NM-1:0] mon_req;
  logic [NM-1:0] mon_one;
  logic [NM-1:0] mon_expw;
  exp_t          mon_e;

  initial begin
    mon_idle = 1'b1;
    mon_ptr  = 0;
    for (int k = 0; k < NM; k++) mon_wait[k] = 0;
    forever begin
      @(negedge clk);
      mon_req = s_read | s_write;
      if (!reset_n) begin
        sbq.delete();
        mon_idle = 1'b1;
        mon_ptr  = 0;
        for (int k = 0; k < NM; k++) mon_wait[k] = 0;
      end else if (mon_idle) begin
        chk("idle_bus", 64'({grant, m_read, m_write}), 64'd0);
        if (mon_req != '0) begin
          mon_w = -1;
          for (int k = 0; k < NM; k++) begin
            int j;
            j = (mon_ptr + k) % NM;
            if (mon_w < 0 && mon_req[j]) mon_w = j;
          end
          mon_e.m    = mon_w;
          mon_e.rd   = s_read[mon_w];
          mon_e.addr = s_address[mon_w*AW +: AW];
          mon_e.data = s_writedata[mon_w*DW +: DW];
          mon_e.be   = s_byteenable[mon_w*BW +: BW];
          sbq.push_back(mon_e);
          mon_ptr  = (mon_w + 1) % NM;
          mon_idle = 1'b0;
        end
      end else if (sbq.size() != 0) begin
        mon_e   = sbq[0];
        mon_w   = mon_e.m;
        mon_one = NM'(1) << mon_w;
        if (!mon_req[mon_w]) begin
          chk("abandon_bus", 64'({m_read, m_write}), 64'd0);
          void'(sbq.pop_front());
          mon_wait[mon_w] = 0;
          mon_idle = 1'b1;
        end else begin
          mon_expw = m_waitrequest ? '1 : ~mon_one;
          chk("grant", 64'(grant), 64'(mon_one));
          chk("m_read", 64'(m_read), 64'(mon_e.rd));
          chk("m_write", 64'(m_write), 64'(!mon_e.rd));
          chk("m_address", 64'(m_address), 64'(mon_e.addr));
          chk("m_byteenable", 64'(m_byteenable), 64'(mon_e.be));
          if (!mon_e.rd) chk("m_writedata", 64'(m_writedata), 64'(mon_e.data));
          chk("s_waitrequest", 64'(s_waitrequest), 64'(mon_expw));
          if (!m_waitrequest) begin
            if (mon_e.rd) chk("s_readdata", 64'(s_readdata), 64'(m_readdata));
            chk("max_wait", 64'((mon_wait[mon_w] > NM - 1) ? mon_wait[mon_w] : 0), 64'd0);
            mon_wait[mon_w] = 0;
            for (int k = 0; k < NM; k++)
              if (k != mon_w && mon_req[k]) mon_wait[k]++;
            void'(sbq.pop_front());
            mon_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int i, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    s_read[i]                  = rd;
    s_write[i]                 = wr;
    s_address[i*AW +: AW]      = a;
    s_writedata[i*DW +: DW]    = d;
    s_byteenable[i*BW +: BW]   = be;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  logic [NM-1:0] seq [6];
  int            ng;
  bit            act [NM];
  int            gap [NM];
  int            age [NM];
  logic [NM-1:0] cmpl;
  int            issued;
  int            completed;
  int            cyc;
  bit            hung;
  bit            in_txn;
  int            stall;
  int unsigned   r;

  initial begin
    reset_n       = 1'b0;
    s_address     = '0;
    s_byteenable  = '0;
    s_writedata   = '0;
    s_read        = '0;
    s_write       = '0;
    m_waitrequest = 1'b1;
    m_readdata    = '0;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_swait", 64'(s_waitrequest), 64'hF);
    chk("rst_mrw", 64'({m_read, m_write}), 64'd0);
    reset_n = 1'b1;

    // single master write, slave ready immediately
    drv(0, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF);
    m_waitrequest = 1'b0;
    tick();
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_mwrite", 64'(m_write), 64'd1);
    chk("t1_addr", 64'(m_address), 64'h1000);
    chk("t1_data", 64'(m_writedata), 64'hA5A5A5A5);
    chk("t1_be", 64'(m_byteenable), 64'hF);
    chk("t1_swait", 64'(s_waitrequest), 64'hE);
    drv(0, 1'b0, 1'b0, 32'h1000, 32'hA5A5A5A5, 4'hF);
    tick();
    chk("t1_grant_off", 64'(grant), 64'd0);
    chk("t1_mwrite_off", 64'(m_write), 64'd0);

    // contention: two masters requesting continuously
    do_reset();
    drv(0, 1'b0, 1'b1, 32'h100, 32'h11112222, 4'h3);
    drv(1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hC);
    m_waitrequest = 1'b0;
    ng = 0;
    for (int k = 0; k < 6; k++) seq[k] = '0;
    for (int c = 0; c < 30 && ng < 6; c++) begin
      tick();
      if (grant != '0) begin
        seq[ng] = grant;
        ng++;
      end
    end
    for (int k = 0; k < 6; k++) chk("t2_order", 64'(seq[k]), 64'(NM'(1) << (k % 2)));
    tick();
    drv(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h3);
    drv(1, 1'b0, 1'b0, 32'h200, 32'h0, 4'hC);
    tick();

    // read with three stall cycles
    do_reset();
    drv(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    tick();
    chk("t3_mread", 64'(m_read), 64'd1);
    chk("t3_addr", 64'(m_address), 64'h20);
    chk("t3_stall", 64'(s_waitrequest), 64'hF);
    tick();
    chk("t3_stall", 64'(s_waitrequest), 64'hF);
    tick();
    chk("t3_stall", 64'(s_waitrequest), 64'hF);
    tick();
    m_waitrequest = 1'b0;
    m_readdata    = 32'h12345678;
    #1;
    chk("t3_swait_done", 64'(s_waitrequest), 64'hD);
    chk("t3_rdata", 64'(s_readdata), 64'h12345678);
    tick();
    drv(1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    chk("t3_after_swait", 64'(s_waitrequest), 64'hF);
    chk("t3_after_grant", 64'(grant), 64'd0);

    // asynchronous reset while stalled
    do_reset();
    drv(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    m_waitrequest = 1'b1;
    tick();
    chk("t4_busy", 64'(m_write), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_mrw", 64'({m_read, m_write}), 64'd0);
    chk("t4_swait", 64'(s_waitrequest), 64'hF);
    chk("t4_grant", 64'(grant), 64'd0);
    drv(0, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
    tick();
    tick();
    reset_n = 1'b1;

    // abandon: master0 drops its write while granted and stalled
    drv(0, 1'b0, 1'b1, 32'h80, 32'h55AA55AA, 4'hF);
    drv(1, 1'b1, 1'b0, 32'h84, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    tick();
    chk("t5_grant0", 64'(grant), 64'h1);
    drv(0, 1'b0, 1'b0, 32'h80, 32'h55AA55AA, 4'hF);
    #1;
    chk("t5_nocycle", 64'({m_read, m_write}), 64'd0);
    tick();
    chk("t5_idle", 64'(grant), 64'd0);
    tick();
    chk("t5_grant1", 64'(grant), 64'h2);
    m_waitrequest = 1'b0;
    m_readdata    = 32'h0BADBEEF;
    tick();
    drv(1, 1'b0, 1'b0, 32'h84, 32'h0, 4'hF);
    m_waitrequest = 1'b1;
    tick();

    // random soak
    do_reset();
    issued    = 0;
    completed = 0;
    cyc       = 0;
    hung      = 1'b0;
    in_txn    = 1'b0;
    stall     = 0;
    for (int i = 0; i < NM; i++) begin
      act[i] = 1'b0;
      gap[i] = $urandom_range(0, 3);
      age[i] = 0;
    end
    while (completed < SOAK_N && cyc < 60000 && !hung) begin
      @(negedge clk);
      cmpl = ~s_waitrequest & (s_read | s_write);
      tick();
      cyc++;
      for (int i = 0; i < NM; i++) begin
        if (act[i]) begin
          if (cmpl[i]) begin
            act[i]     = 1'b0;
            completed++;
            s_read[i]  = 1'b0;
            s_write[i] = 1'b0;
            gap[i]     = $urandom_range(0, 3);
            age[i]     = 0;
          end else begin
            age[i]++;
            if (age[i] > 200) hung = 1'b1;
          end
        end
        if (!act[i] && issued < SOAK_N) begin
          if (gap[i] == 0) begin
            r = $urandom_range(0, 15);
            drv(i, (r == 0) ? 1'b1 : (r < 8), (r == 0) ? 1'b1 : (r >= 8),
                $urandom, $urandom, 4'($urandom_range(1, 15)));
            act[i] = 1'b1;
            issued++;
          end else begin
            gap[i]--;
          end
        end
      end
      #1;
      if (m_read | m_write) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          stall  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        end else if (stall > 0) begin
          stall--;
        end
        m_waitrequest = (stall != 0);
        m_readdata    = rd_pat(m_address);
      end else begin
        in_txn        = 1'b0;
        m_waitrequest = 1'($urandom_range(0, 1));
        m_readdata    = $urandom;
      end
    end
    if (hung) chk("soak_timeout", 64'd1, 64'd0);
    chk("soak_done", 64'(completed), 64'(SOAK_N));
    s_read  = '0;
    s_write = '0;
    tick();
    tick();
    tick();
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
